// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit: forward-select codes and the
// multiply/divide busy FSM state encoding.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int MD_CNT_W = 6;

endpackage

// File: rtl/hazard_unit_md_busy_ctr.sv
// Multiply/divide occupancy tracker: an IDLE/BUSY FSM with a down-counter
// that keeps md_busy_o high for MD_CYCLES cycles after each start pulse.
module md_busy_ctr
    import hazard_unit_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start_i,
    output logic md_busy_o
);

    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES - 1);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (md_start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = MD_LOAD;
                end
            end
            MD_BUSY: begin
                // A new start always restarts the full busy period, even on the last cycle.
                if (md_start_i) begin
                    cnt_d = MD_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign md_busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: E-stage forwarding, load-use / branch / mult-div stalls.
// Optional D-stage branch forwarding and branch stalls via `EARLY_BRANCH_EN.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       MdStartE,
    input  logic       MdUseD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       MdBusy
);

    logic lwstall;
    logic branchstall;
    logic mdstall;
    logic stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (src != 5'd0 && src == WriteRegM && RegWriteM) return FWD_MEM;
        if (src != 5'd0 && src == WriteRegW && RegWriteW) return FWD_WB;
        return FWD_RF;
    endfunction

    assign ForwardAE = fwd_sel(RsE);
    assign ForwardBE = fwd_sel(RtE);

    assign lwstall = MemtoRegE && (RtE == RsD || RtE == RtD);

`ifdef EARLY_BRANCH_EN
    assign ForwardAD = (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
    assign ForwardBD = (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;

    // A branch compares in D, so an ALU result still in E or a load still in M is too late.
    assign branchstall = BranchD &&
        ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
         (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
`else
    logic unused_branch_inputs;

    assign ForwardAD   = 1'b0;
    assign ForwardBD   = 1'b0;
    assign branchstall = 1'b0;
    assign unused_branch_inputs = &{BranchD, RegWriteE, WriteRegE, MemtoRegM};
`endif

    md_busy_ctr #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_busy_ctr (
        .clk        (clk),
        .rst        (rst),
        .md_start_i (MdStartE),
        .md_busy_o  (MdBusy)
    );

    assign mdstall = MdUseD && MdBusy;
    assign stall   = lwstall || branchstall || mdstall;

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

endmodule
